// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
//
// Sequencer in front of the shared ripple-carry adder. A request (ADD, SUB,
// ADDC or unsigned shift-add MUL) is accepted in IDLE. The block then drives
// the adder operands from registers and holds them for SETTLE cycles so the
// gate-delay adder can settle. After that it captures the sum and computes
// the N/Z/C/O flags itself. The response is held until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   upstream handshake (ready only in IDLE)
//   req_op                00 ADD, 01 SUB, 10 ADDC, 11 MUL
//   req_a, req_b          operands
//   add_a, add_b, add_cin registered drive into the external adder
//   add_s, add_cout       adder sum and carry-out
//   rsp_valid/rsp_ready   downstream handshake
//   rsp_result            result word
//   rsp_flags             {N, Z, C, O}
// ---------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
);

    // The settle counter is loaded with SETTLE-1 and captures at zero, so it
    // only ever has to hold values up to SETTLE-1.
    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_ADDC,
        OP_MUL
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_WAIT,
        MUL_STEP,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    op_t              op_q;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             c_flag;

    logic [WIDTH-1:0] mcand_shl;
    logic [WIDTH-1:0] mplier_shr;
    logic             sum_zero;
    logic             acc_zero;
    logic             arith_ovf;

    // Next multiplicand/multiplier values for the end of a MUL step. Deciding
    // on the shifted multiplier lets each step's final edge choose the next
    // step directly. The step count never exceeds WIDTH, because WIDTH right
    // shifts always empty the multiplier.
    assign mcand_shl  = mcand << 1;
    assign mplier_shr = mplier >> 1;
    assign sum_zero   = (add_s == '0);
    assign acc_zero   = (acc == '0);

    // Signed overflow uses the original operand signs. For SUB, add_b holds
    // ~b, so b's sign is kept separately at acceptance.
    assign arith_ovf = (op_q == OP_SUB) ?
                       ((a_msb != b_msb) && (add_s[WIDTH-1] != a_msb)) :
                       ((a_msb == b_msb) && (add_s[WIDTH-1] != a_msb));

    // Ready is a pure decode of the state register. Reset forces IDLE
    // asynchronously, so ready is also high while reset is held.
    assign req_ready = (state == IDLE);

    // Main sequencer. Every output except req_ready is a register written
    // here. add_* are loaded only on the edge that starts a settle window, so
    // they stay constant while the adder settles. MUL runs as a chain of
    // steps. A 1-bit step reuses SETTLE_WAIT for its add. A 0-bit step sits
    // in MUL_STEP for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= OP_ADD;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            c_flag     <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= op_t'(req_op);
                        a_msb <= req_a[WIDTH-1];
                        b_msb <= req_b[WIDTH-1];
                        if (op_t'(req_op) == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= req_a;
                            mplier <= req_b;
                            if (req_b[0]) begin
                                add_a   <= '0;
                                add_b   <= req_a;
                                add_cin <= 1'b0;
                                cnt     <= CNT_LOAD;
                                state   <= SETTLE_WAIT;
                            end else begin
                                state <= MUL_STEP;
                            end
                        end else begin
                            add_a   <= req_a;
                            add_b   <= (op_t'(req_op) == OP_SUB) ? ~req_b : req_b;
                            add_cin <= (op_t'(req_op) == OP_SUB)  ? 1'b1 :
                                       (op_t'(req_op) == OP_ADDC) ? c_flag : 1'b0;
                            cnt     <= CNT_LOAD;
                            state   <= SETTLE_WAIT;
                        end
                    end
                end

                SETTLE_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (op_q == OP_MUL) begin
                        acc    <= add_s;
                        mcand  <= mcand_shl;
                        mplier <= mplier_shr;
                        if (mplier_shr == '0) begin
                            rsp_result <= add_s;
                            rsp_flags  <= {add_s[WIDTH-1], sum_zero, 2'b00};
                            c_flag     <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= DONE;
                        end else if (mplier_shr[0]) begin
                            add_a   <= add_s;
                            add_b   <= mcand_shl;
                            add_cin <= 1'b0;
                            cnt     <= CNT_LOAD;
                        end else begin
                            state <= MUL_STEP;
                        end
                    end else begin
                        rsp_result <= add_s;
                        rsp_flags  <= {add_s[WIDTH-1], sum_zero, add_cout, arith_ovf};
                        c_flag     <= add_cout;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end

                MUL_STEP: begin
                    mcand  <= mcand_shl;
                    mplier <= mplier_shr;
                    if (mplier_shr == '0) begin
                        rsp_result <= acc;
                        rsp_flags  <= {acc[WIDTH-1], acc_zero, 2'b00};
                        c_flag     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (mplier_shr[0]) begin
                        add_a   <= acc;
                        add_b   <= mcand_shl;
                        add_cin <= 1'b0;
                        cnt     <= CNT_LOAD;
                        state   <= SETTLE_WAIT;
                    end
                end

                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_seq_ctrl
//
// Bench for adder_seq_ctrl. It includes a behavioural ripple-carry adder
// whose sum is deliberately wrong until its inputs have been stable long
// enough, so capturing too early gives a bad result. The driver pushes the
// expected response for each accepted request into a queue. The monitor pops
// and compares each new response when it appears. The expected values come
// from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 4;
    localparam int PERIOD = 10;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] ADDC = 2'b10;
    localparam logic [1:0] MUL  = 2'b11;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        int          acc_edge;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   model_c = 1'b0;
    bit   rsp_seen = 1'b0;

    bit   rand_ready = 1'b0;
    bit   force_ready = 1'b1;
    bit   rand_bit = 1'b1;

    adder_seq_ctrl #(
        .WIDTH (WIDTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_flags (rsp_flags)
    );

    // Free-running clock, with an edge counter used to measure latency.
    always #(PERIOD/2) clk = ~clk;

    always @(posedge clk) cycle++;

    // Consumer ready: either a fixed level chosen by the main sequence or a
    // random level refreshed every cycle.
    always @(negedge clk) rand_bit = ($urandom_range(0, 3) != 0);

    assign rsp_ready = rand_ready ? rand_bit : force_ready;

    // Slow-adder model. Any change of the inputs restarts a settle timer.
    // The sum is scrambled until (SETTLE-1) cycles plus half a cycle have
    // passed, which is just before the edge where a correct capture happens.
    time          last_change = 0;
    logic [31:0]  seen_a = '0;
    logic [31:0]  seen_b = '0;
    logic         seen_cin = 1'b0;
    logic [32:0]  exact_sum;

    always @(add_a or add_b or add_cin or negedge clk) begin
        if (add_a !== seen_a || add_b !== seen_b || add_cin !== seen_cin) begin
            last_change = $time;
            seen_a      = add_a;
            seen_b      = add_b;
            seen_cin    = add_cin;
        end
        exact_sum = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
        if (($time - last_change) >= time'((SETTLE-1)*PERIOD + PERIOD/2))
            {add_cout, add_s} = exact_sum;
        else
            {add_cout, add_s} = exact_sum ^ 33'h1_A5A5_5A5A;
    end

    // Compare one value. Report a failure and count every call.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference behaviour worked out from the operation definitions. It
    // uses wide unsigned and signed arithmetic, a product, and a count of the
    // multiplier bits up to its highest set bit.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input bit cin,
                                     output logic [31:0] res, output logic [3:0] flags,
                                     output int lat, output bit cout);
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned wide;
        longint          sr;
        bit              o;
        o    = 1'b0;
        cout = 1'b0;
        lat  = SETTLE;
        case (op)
            ADD: begin
                wide = ua + ub;
                res  = wide[31:0];
                cout = wide[32];
                sr   = sa + sb;
                o    = (sr > MAXS) || (sr < MINS);
            end
            SUB: begin
                res  = a - b;
                cout = (a >= b);
                sr   = sa - sb;
                o    = (sr > MAXS) || (sr < MINS);
            end
            ADDC: begin
                wide = ua + ub + longint'(cin);
                res  = wide[31:0];
                cout = wide[32];
                sr   = sa + sb + longint'(cin);
                o    = (sr > MAXS) || (sr < MINS);
            end
            default: begin
                wide = ua * ub;
                res  = wide[31:0];
                lat  = 0;
                for (int i = 0; i < 32; i++)
                    if ((b >> i) != 0) lat += b[i] ? SETTLE : 1;
                if (b == 0) lat = 1;
            end
        endcase
        flags = {res[31], (res == 0), cout, o};
    endfunction

    // Drive one request, wait (with a bound) for it to be accepted, then push
    // its expected response into the scoreboard.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string name);
        exp_t        e;
        bit          c_next;
        int          waited;
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput({name, "_accept_timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        refModel(op, a, b, model_c, e.res, e.flags, e.lat, c_next);
        model_c    = c_next;
        e.acc_edge = cycle + 1;
        e.name     = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait (bounded) until every issued request has been answered and taken.
    task automatic waitIdle();
        int n = 0;
        while ((sb_q.size() != 0 || rsp_valid || !req_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_idle", {63'd0, (sb_q.size() == 0 && req_ready)}, 64'd1);
    endtask

    // Monitor: on the first cycle of each response, pop the oldest expected
    // entry and compare result, flags and latency.
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_seen = 1'b0;
        end else if (rsp_valid && !rsp_seen) begin
            rsp_seen = 1'b1;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_rsp", {60'd0, rsp_flags}, 64'hDEAD);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput({mon_e.name, "_result"}, {32'd0, rsp_result}, {32'd0, mon_e.res});
                checkOutput({mon_e.name, "_flags"}, {60'd0, rsp_flags}, {60'd0, mon_e.flags});
                checkOutput({mon_e.name, "_latency"}, 64'(cycle - mon_e.acc_edge), 64'(mon_e.lat));
            end
        end else if (!rsp_valid) begin
            rsp_seen = 1'b0;
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, stall, mid-operation reset, then
    // random traffic.
    initial begin
        int n;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        req_valid = 1'b0;
        req_op    = ADD;
        req_a     = '0;
        req_b     = '0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_rsp_result", {32'd0, rsp_result}, 64'd0);
        checkOutput("reset_rsp_flags", {60'd0, rsp_flags}, 64'd0);
        checkOutput("reset_add_a", {32'd0, add_a}, 64'd0);
        checkOutput("reset_add_b", {32'd0, add_b}, 64'd0);
        checkOutput("reset_add_cin", {63'd0, add_cin}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(ADD, 32'd1, 32'd1, "add_1_1");
        waitIdle();
        applyStimulus(SUB, 32'd0, 32'd1, "sub_0_1");
        waitIdle();
        applyStimulus(SUB, 32'd3, 32'd3, "sub_3_3");
        waitIdle();
        applyStimulus(ADD, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        waitIdle();
        applyStimulus(ADD, 32'd3, 32'hFFFF_FFFF, "add_carry");
        waitIdle();
        applyStimulus(ADDC, 32'd0, 32'd0, "addc_0_0");
        waitIdle();
        applyStimulus(MUL, 32'd3, 32'd5, "mul_3_5");
        waitIdle();
        applyStimulus(MUL, 32'd7, 32'd0, "mul_7_0");
        waitIdle();

        force_ready = 1'b0;
        applyStimulus(ADD, 32'd10, 32'd20, "add_stall");
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_rsp_arrived", {63'd0, rsp_valid}, 64'd1);
        req_op    = ADD;
        req_a     = 32'd5;
        req_b     = 32'd5;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            checkOutput("stall_rsp_result", {32'd0, rsp_result}, 64'd30);
            checkOutput("stall_rsp_flags", {60'd0, rsp_flags}, 64'd0);
            checkOutput("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        req_valid   = 1'b0;
        force_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("release_req_ready", {63'd0, req_ready}, 64'd1);
        waitIdle();

        applyStimulus(ADD, 32'd3, 32'hFFFF_FFFF, "add_carry2");
        waitIdle();
        applyStimulus(MUL, 32'h0000_1234, 32'd3, "mul_rst");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("midrst_add_a", {32'd0, add_a}, 64'd0);
        checkOutput("midrst_add_b", {32'd0, add_b}, 64'd0);
        checkOutput("midrst_add_cin", {63'd0, add_cin}, 64'd0);
        checkOutput("midrst_rsp_result", {32'd0, rsp_result}, 64'd0);
        sb_q.delete();
        model_c = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(ADDC, 32'd0, 32'd0, "addc_after_rst");
        waitIdle();
        applyStimulus(ADD, 32'd2, 32'd2, "add_2_2");
        waitIdle();

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (rop == MUL && $urandom_range(0, 1) == 1) rb = 32'($urandom_range(0, 255));
            applyStimulus(rop, ra, rb, "rand");
        end
        waitIdle();
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
